// File: rtl/xadc_drp_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : xadc_drp_arbiter_pkg
//  Brief    : Shared DRP widths, address type and arbiter state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package xadc_drp_arbiter_pkg;

    localparam int XADC_DRP_DATA_WIDTH = 16;
    localparam int XADC_DRP_ADDR_WIDTH = 7;

    typedef logic [XADC_DRP_ADDR_WIDTH-1:0] xadc_drp_addr_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RDY = 2'd2
    } xadc_drp_arbiter_state_t;

endpackage
`default_nettype wire

// File: rtl/xadc_drp_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module   : xadc_drp_rr_picker
//  Brief    : Combinational round-robin picker. Scans the request vector
//             starting one past the last grant, wrapping, and returns the
//             first requester found.
//  Revision : 1.0 - initial release
// ============================================================================
module xadc_drp_rr_picker #(
    parameter int NUM_REQUESTERS = 2
) (
    input  logic [NUM_REQUESTERS-1:0]         req_valid_i,
    input  logic [$clog2(NUM_REQUESTERS)-1:0] last_grant_i,
    output logic [$clog2(NUM_REQUESTERS)-1:0] winner_o,
    output logic                              any_valid_o
);

    localparam int IDX_W = $clog2(NUM_REQUESTERS);

    // First set bit in rotated order; k = NUM_REQUESTERS revisits the last
    // grant itself so a lone repeat requester is still served.
    always_comb begin
        logic found;
        int   idx;
        found    = 1'b0;
        idx      = 0;
        winner_o = '0;
        for (int k = 1; k <= NUM_REQUESTERS; k++) begin
            idx = (int'(last_grant_i) + k) % NUM_REQUESTERS;
            if (!found && req_valid_i[idx]) begin
                winner_o = IDX_W'(idx);
                found    = 1'b1;
            end
        end
        any_valid_o = |req_valid_i;
    end

endmodule
`default_nettype wire

// File: rtl/xadc_drp_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : xadc_drp_arbiter
//  Brief    : Round-robin arbiter sharing one XADC DRP port among
//             NUM_REQUESTERS clients. One transaction in flight at a time;
//             the response pulse goes to the granted client only.
//             Optional DRDY timeout: define XADC_DRP_ARBITER_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module xadc_drp_arbiter
    import xadc_drp_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTERS = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                          xadc_dclk,
    input  logic                                          xadc_reset,
    input  logic [NUM_REQUESTERS-1:0]                     req_valid,
    input  logic [NUM_REQUESTERS-1:0]                     req_write,
    input  logic [NUM_REQUESTERS*XADC_DRP_ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQUESTERS*XADC_DRP_DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQUESTERS-1:0]                     req_ready,
    output logic [NUM_REQUESTERS-1:0]                     rsp_valid,
    output logic [XADC_DRP_DATA_WIDTH-1:0]                rsp_data,
    output logic [NUM_REQUESTERS-1:0]                     rsp_err,
    output logic [XADC_DRP_ADDR_WIDTH-1:0]                xadc_daddr,
    output logic                                          xadc_den,
    output logic                                          xadc_dwe,
    output logic [XADC_DRP_DATA_WIDTH-1:0]                xadc_di,
    input  logic                                          xadc_drdy,
    input  logic [XADC_DRP_DATA_WIDTH-1:0]                xadc_do
);

    localparam int IDX_W = $clog2(NUM_REQUESTERS);

    if (NUM_REQUESTERS < 2 || NUM_REQUESTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("xadc_drp_arbiter: NUM_REQUESTERS must be 2..8, TIMEOUT_CYCLES >= 1");
    end

    xadc_drp_arbiter_state_t          state_q;
    // Doubles as the current grant while a transaction is in flight.
    logic [IDX_W-1:0]                 last_grant_q;
    logic                             den_q;
    logic                             dwe_q;
    xadc_drp_addr_t                   daddr_q;
    logic [XADC_DRP_DATA_WIDTH-1:0]   di_q;
    logic [NUM_REQUESTERS-1:0]        ready_q;
    logic [NUM_REQUESTERS-1:0]        rsp_valid_q;
    logic [XADC_DRP_DATA_WIDTH-1:0]   rsp_data_q;

    logic [IDX_W-1:0]                 w_pick_idx;
    logic                             w_pick_any;
    xadc_drp_addr_t                   w_win_addr;
    logic [XADC_DRP_DATA_WIDTH-1:0]   w_win_wdata;
    logic                             w_win_write;

`ifdef XADC_DRP_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]                 cnt_q;
    logic [NUM_REQUESTERS-1:0]        rsp_err_q;
`endif

    xadc_drp_rr_picker #(
        .NUM_REQUESTERS (NUM_REQUESTERS)
    ) u_picker (
        .req_valid_i  (req_valid),
        .last_grant_i (last_grant_q),
        .winner_o     (w_pick_idx),
        .any_valid_o  (w_pick_any)
    );

    assign w_win_addr  = req_addr[int'(w_pick_idx)*XADC_DRP_ADDR_WIDTH +: XADC_DRP_ADDR_WIDTH];
    assign w_win_wdata = req_wdata[int'(w_pick_idx)*XADC_DRP_DATA_WIDTH +: XADC_DRP_DATA_WIDTH];
    assign w_win_write = req_write[w_pick_idx];

    // Arbitration FSM: grant in IDLE, pulse DEN in ISSUE, collect DRDY.
    always_ff @(posedge xadc_dclk or posedge xadc_reset) begin
        if (xadc_reset) begin
            state_q      <= IDLE;
            last_grant_q <= IDX_W'(NUM_REQUESTERS - 1);
            den_q        <= 1'b0;
            dwe_q        <= 1'b0;
            daddr_q      <= '0;
            di_q         <= '0;
            ready_q      <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
`ifdef XADC_DRP_ARBITER_TIMEOUT_EN
            cnt_q        <= '0;
            rsp_err_q    <= '0;
`endif
        end else begin
            // Strobes are single-cycle pulses by default.
            den_q       <= 1'b0;
            dwe_q       <= 1'b0;
            ready_q     <= '0;
            rsp_valid_q <= '0;
`ifdef XADC_DRP_ARBITER_TIMEOUT_EN
            rsp_err_q   <= '0;
`endif
            case (state_q)
                IDLE: begin
                    if (w_pick_any) begin
                        daddr_q               <= w_win_addr;
                        di_q                  <= w_win_wdata;
                        dwe_q                 <= w_win_write;
                        den_q                 <= 1'b1;
                        ready_q[w_pick_idx]   <= 1'b1;
                        last_grant_q          <= w_pick_idx;
                        state_q               <= ISSUE;
                    end
                end
                // DRDY may already arrive during the DEN cycle itself.
                ISSUE, WAIT_RDY: begin
                    if (xadc_drdy) begin
                        rsp_valid_q[last_grant_q] <= 1'b1;
                        rsp_data_q                <= xadc_do;
                        state_q                   <= IDLE;
                    end else if (state_q == ISSUE) begin
                        state_q <= WAIT_RDY;
`ifdef XADC_DRP_ARBITER_TIMEOUT_EN
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_valid_q[last_grant_q] <= 1'b1;
                        rsp_err_q[last_grant_q]   <= 1'b1;
                        rsp_data_q                <= '0;
                        state_q                   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign xadc_daddr = daddr_q;
    assign xadc_den   = den_q;
    assign xadc_dwe   = dwe_q;
    assign xadc_di    = di_q;
`ifdef XADC_DRP_ARBITER_TIMEOUT_EN
    assign rsp_err    = rsp_err_q;
`else
    assign rsp_err    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_xadc_drp_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_xadc_drp_arbiter
//  Brief    : Directed bench for xadc_drp_arbiter (3 clients) with a DRP
//             responder model and an expected-transaction scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_xadc_drp_arbiter;
    import xadc_drp_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int TO = 8;
    localparam int DW = XADC_DRP_DATA_WIDTH;
    localparam int AW = XADC_DRP_ADDR_WIDTH;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready, rsp_valid, rsp_err;
    logic [DW-1:0]   rsp_data, xadc_di, do_v;
    logic [AW-1:0]   xadc_daddr;
    logic            xadc_den, xadc_dwe, drdy;

    always #5 clk = ~clk;

    xadc_drp_arbiter #(
        .NUM_REQUESTERS (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .xadc_dclk  (clk),
        .xadc_reset (rst),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .xadc_daddr (xadc_daddr),
        .xadc_den   (xadc_den),
        .xadc_dwe   (xadc_dwe),
        .xadc_di    (xadc_di),
        .xadc_drdy  (drdy),
        .xadc_do    (do_v)
    );

    typedef struct {
        int            client;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        bit            err;
        int            lat;
    } txn_t;

    txn_t          issue_q[$];
    txn_t          rsp_q[$];
    txn_t          mon_t;
    logic [DW-1:0] shadow[128];
    logic [DW-1:0] mem[128];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    int            rdy_delay = 1;
    int            den_cyc = 0;
    bit            outstanding = 0;
    int            r_delay;
    logic [AW-1:0] r_addr;
    logic          r_we;
    logic [DW-1:0] r_di;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // DRP slave: answers each DEN after rdy_delay cycles (negative: never).
    initial begin
        drdy = 1'b0;
        do_v = '0;
        for (int i = 0; i < 128; i++) mem[i] = 16'h5A2D + 16'(i);
        forever begin
            @(posedge clk); #1;
            if (xadc_den && !rst) begin
                r_delay = rdy_delay;
                r_addr  = xadc_daddr;
                r_we    = xadc_dwe;
                r_di    = xadc_di;
                if (r_delay >= 0) begin
                    repeat (r_delay) @(posedge clk);
                    if (r_delay > 0) #1;
                    drdy = 1'b1;
                    do_v = mem[r_addr];
                    if (r_we) mem[r_addr] = r_di;
                    @(posedge clk); #1;
                    drdy = 1'b0;
                    do_v = 16'hDEAD;
                end
            end
        end
    end

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            outstanding = 0;
            issue_q.delete();
            rsp_q.delete();
        end else begin
            if (rsp_valid != '0) begin
                if (rsp_q.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    mon_t = rsp_q.pop_front();
                    check("rsp_valid", 32'(rsp_valid), 32'd1 << mon_t.client);
                    check("rsp_data", 32'(rsp_data), 32'(mon_t.rdata));
                    check("rsp_err", 32'(rsp_err), mon_t.err ? (32'd1 << mon_t.client) : 32'd0);
                    check("rsp_latency", 32'(cyc - den_cyc), 32'(mon_t.lat));
                end
                outstanding = 0;
            end
            if (xadc_den) begin
                check("den_no_overlap", 32'(outstanding), 32'd0);
                if (issue_q.size() == 0) begin
                    check("den_unexpected", 32'(xadc_den), 32'd0);
                end else begin
                    mon_t = issue_q.pop_front();
                    check("grant_ready", 32'(req_ready), 32'd1 << mon_t.client);
                    check("daddr", 32'(xadc_daddr), 32'(mon_t.addr));
                    check("dwe", 32'(xadc_dwe), 32'(mon_t.we));
                    if (mon_t.we) check("di", 32'(xadc_di), 32'(mon_t.wdata));
                    rsp_q.push_back(mon_t);
                end
                den_cyc     = cyc;
                outstanding = 1;
            end else if (req_ready != '0 || xadc_dwe) begin
                check("strobe_without_den", {req_ready, xadc_dwe}, 32'd0);
            end
        end
    end

    task automatic push_exp(input int c, input bit we, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input int delay);
        txn_t t;
        t.client = c;
        t.we     = we;
        t.addr   = a;
        t.wdata  = wd;
        t.err    = (delay < 0);
        t.rdata  = (delay < 0) ? '0 : shadow[a];
        t.lat    = (delay < 0) ? TO + 1 : delay + 1;
        if (we && delay >= 0) shadow[a] = wd;
        issue_q.push_back(t);
    endtask

    task automatic drive_req(input int c, input bit we, input logic [AW-1:0] a,
                             input logic [DW-1:0] wd);
        req_write[c]          = we;
        req_addr[c*AW +: AW]  = a;
        req_wdata[c*DW +: DW] = wd;
        req_valid[c]          = 1'b1;
    endtask

    task automatic wait_ready(input int c);
        bit seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk); #1;
            if (req_ready[c]) seen = 1;
        end
        req_valid[c] = 1'b0;
        if (!seen) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge clk); #1;
            if (issue_q.size() == 0 && rsp_q.size() == 0) done = 1;
        end
        if (!done) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic single(input int c, input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input int delay);
        rdy_delay = delay;
        push_exp(c, we, a, wd, delay);
        drive_req(c, we, a, wd);
        wait_ready(c);
        wait_idle();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_den"}, 32'(xadc_den), 32'd0);
        check({tag, "_dwe"}, 32'(xadc_dwe), 32'd0);
        check({tag, "_daddr"}, 32'(xadc_daddr), 32'd0);
        check({tag, "_di"}, 32'(xadc_di), 32'd0);
        check({tag, "_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt[N];
        int rdy_at[$];
        rst       = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < 128; i++) shadow[i] = 16'h5A2D + 16'(i);
        repeat (3) @(posedge clk); #1;
        check_outputs_zero("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Read of 0x03 answered two cycles after DEN.
        single(0, 1'b0, 7'h03, 16'h0000, 2);
        // Write then read-back through another client.
        single(1, 1'b1, 7'h41, 16'h1234, 1);
        single(2, 1'b0, 7'h41, 16'h0000, 3);

        // Reset while waiting for DRDY; the late DRDY must be ignored.
        rdy_delay = 5;
        push_exp(1, 1'b0, 7'h10, 16'h0000, 5);
        drive_req(1, 1'b0, 7'h10, 16'h0000);
        wait_ready(1);
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_outputs_zero("midreset");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("stale_drdy_rsp", 32'(rsp_valid), 32'd0);
        end

        // All three clients contend: expect grants 0,1,2,0,1,2.
        rdy_delay = 1;
        for (int r = 0; r < 2; r++) begin
            push_exp(0, 1'b0, 7'h05, 16'h0000, 1);
            push_exp(1, 1'b0, 7'h06, 16'h0000, 1);
            push_exp(2, 1'b1, 7'h07, 16'hA5A5, 1);
        end
        drive_req(0, 1'b0, 7'h05, 16'h0000);
        drive_req(1, 1'b0, 7'h06, 16'h0000);
        drive_req(2, 1'b1, 7'h07, 16'hA5A5);
        for (int c = 0; c < N; c++) cnt[c] = 0;
        for (int i = 0; i < 100 && req_valid != '0; i++) begin
            @(posedge clk); #1;
            for (int c = 0; c < N; c++) begin
                if (req_ready[c]) begin
                    cnt[c]++;
                    if (cnt[c] == 2) req_valid[c] = 1'b0;
                end
            end
        end
        check("rr_all_served", 32'(req_valid), 32'd0);
        wait_idle();

        // Back-to-back with DRDY in the DEN cycle: one grant every 2 cycles.
        rdy_delay = 0;
        for (int r = 0; r < 3; r++) push_exp(1, 1'b0, 7'h41, 16'h0000, 0);
        drive_req(1, 1'b0, 7'h41, 16'h0000);
        for (int i = 0; i < 40 && rdy_at.size() < 3; i++) begin
            @(posedge clk); #1;
            if (req_ready[1]) rdy_at.push_back(cyc);
        end
        req_valid[1] = 1'b0;
        check("b2b_grants", 32'(rdy_at.size()), 32'd3);
        if (rdy_at.size() == 3) begin
            check("b2b_period0", 32'(rdy_at[1] - rdy_at[0]), 32'd2);
            check("b2b_period1", 32'(rdy_at[2] - rdy_at[1]), 32'd2);
        end
        wait_idle();

`ifdef XADC_DRP_ARBITER_TIMEOUT_EN
        // No DRDY at all: error response after TO WAIT_RDY cycles.
        single(0, 1'b0, 7'h03, 16'h0000, -1);
        single(0, 1'b0, 7'h03, 16'h0000, 1);
`endif

        repeat (3) @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
